// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM states and queue entry type for the fetch front end
package fetch_pkg;
  localparam int DEF_WORD = 64;
  localparam int DEF_INSTR_LEN = 32;
  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_e;
  typedef struct packed {
    logic [DEF_WORD-1:0] pc;
    logic [DEF_INSTR_LEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// sync_fifo: power-of-two circular buffer with push/pop/flush and occupancy count
module sync_fifo #(
  parameter int W = 8,
  parameter int D = 4,
  localparam int AW = $clog2(D),
  localparam int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: credit-limited sequential fetcher with PC-tagged instruction queue and redirect flush
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WORD = DEF_WORD,
  parameter int INSTR_LEN = DEF_INSTR_LEN,
  parameter int DEPTH = 4,
  parameter logic [WORD-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 redirect_valid,
  input  logic [WORD-1:0]      redirect_target,
  input  logic                 halt,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [WORD-1:0]      imem_req_addr,
  input  logic                 imem_resp_valid,
  input  logic [INSTR_LEN-1:0] imem_resp_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD-1:0]      out_pc,
  output logic [INSTR_LEN-1:0] out_instr
);
  localparam int CW = $clog2(DEPTH + 1);
  state_e state;
  logic [WORD-1:0] fetch_pc, pend_pc;
  logic [CW-1:0] outstanding, drop_cnt, q_count, pend_count;
  logic [WORD+INSTR_LEN-1:0] q_dout;
  logic redir, req_fire, resp_acc, drop, q_push, pend_pop;
  assign redir = redirect_valid && state != BOOT;
  assign imem_req_valid = state == RUN && !halt && !redirect_valid &&
                          ({1'b0, q_count} + {1'b0, outstanding} < (CW + 1)'(DEPTH));
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign resp_acc = imem_resp_valid && outstanding != '0;
  assign drop = resp_acc && (drop_cnt != '0 || redir);
  assign q_push = resp_acc && !drop;
  assign pend_pop = q_push && pend_count != '0;
  assign out_valid = q_count != '0;
  assign {out_pc, out_instr} = q_dout;
  // on redirect every request still in flight is stale, including ones already marked for dropping
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= BOOT;
      fetch_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
    end else begin
      state <= (state == BOOT || !halt) ? RUN : HALTED;
      fetch_pc <= redir ? redirect_target : req_fire ? fetch_pc + WORD'(PC_STEP) : fetch_pc;
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_acc);
      drop_cnt <= redir ? outstanding - CW'(resp_acc) : drop_cnt - CW'(drop_cnt != '0 && resp_acc);
    end
  sync_fifo #(.W(WORD), .D(DEPTH)) u_pend (
    .clk(clk), .reset(reset), .push(req_fire), .din(fetch_pc), .pop(pend_pop),
    .flush(redir), .dout(pend_pc), .count(pend_count)
  );
  sync_fifo #(.W(WORD + INSTR_LEN), .D(DEPTH)) u_queue (
    .clk(clk), .reset(reset), .push(q_push), .din({pend_pc, imem_resp_instr}),
    .pop(out_valid && out_ready), .flush(redir), .dout(q_dout), .count(q_count)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: vector table plus scoreboarded scenarios against a latency-configurable memory model
module tb_fetch_queue;
  import fetch_pkg::*;
  logic clk = 0, reset = 0, redirect_valid = 0, halt = 0, imem_req_ready = 1;
  logic imem_resp_valid = 0, out_ready = 0;
  logic [63:0] redirect_target = '0;
  logic [31:0] imem_resp_instr = '0;
  logic imem_req_valid, out_valid;
  logic [63:0] imem_req_addr, out_pc;
  logic [31:0] out_instr;
  always #5 clk = ~clk;
  fetch_queue #(.WORD(64), .INSTR_LEN(32), .DEPTH(4), .RESET_PC(64'h0), .PC_STEP(4)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt(halt), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_instr(imem_resp_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
  );
  typedef struct {logic [63:0] addr; int due;} mreq_t;
  typedef struct {logic rdy; logic exp_rv; logic [63:0] exp_addr; logic exp_ov; logic [63:0] exp_pc;} vec_t;
  mreq_t mq[$];
  fetch_entry_t sb[$];
  vec_t tbl[6];
  int checks = 0, errors = 0, cyc = 0, lat = 1, fires = 0, fires0;
  logic cur_rv, cur_hlt;
  logic [63:0] cur_tgt, exp_addr;
  function automatic logic [31:0] instr_of(logic [63:0] a);
    return a[63:32] ^ a[31:0] ^ 32'h1357_9bdf;
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic drive(input logic rdy, input logic hlt, input logic rv, input logic [63:0] tgt);
    out_ready = rdy; halt = hlt; redirect_valid = rv; redirect_target = tgt; imem_req_ready = 1;
    cur_rv = rv; cur_tgt = tgt; cur_hlt = hlt;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1;
      imem_resp_instr = instr_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_resp_valid = 0;
      imem_resp_instr = '0;
    end
    #1;
  endtask
  task automatic finish_cyc();
    fetch_entry_t e;
    if (cur_hlt || cur_rv) chk("no_req_halt_redir", imem_req_valid, 0);
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_addr);
      mq.push_back('{addr: imem_req_addr, due: cyc + lat});
      exp_addr += 64'd4;
      fires++;
    end
    if (cur_rv) exp_addr = cur_tgt;
    if (out_valid && out_ready && sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_pc", out_pc, e.pc);
      chk("out_instr", out_instr, e.instr);
    end
    @(negedge clk);
    cyc++;
  endtask
  task automatic step(input logic rdy, input logic hlt, input logic rv, input logic [63:0] tgt);
    drive(rdy, hlt, rv, tgt);
    finish_cyc();
  endtask
  task automatic do_reset(input int l);
    @(negedge clk);
    reset = 0; redirect_valid = 0; halt = 0; out_ready = 0; imem_resp_valid = 0;
    mq.delete(); sb.delete();
    exp_addr = 0; lat = l; fires = 0;
    @(negedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    @(negedge clk);
    reset = 1;
    cyc = 0;
  endtask
  task automatic push_seq(input logic [63:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [63:0] p;
      p = start + 64'(4 * i);
      sb.push_back('{pc: p, instr: instr_of(p)});
    end
  endtask
  task automatic run_out(input int maxc);
    int i = 0;
    while (sb.size() > 0 && i < maxc) begin
      step(1, 0, 0, 0);
      i++;
    end
    chk("drain_timeout_left", sb.size(), 0);
  endtask
  initial begin
    tbl[0] = '{1, 0, 64'h0, 0, 64'h0};
    tbl[1] = '{1, 1, 64'h0, 0, 64'h0};
    tbl[2] = '{1, 1, 64'h4, 0, 64'h0};
    tbl[3] = '{1, 1, 64'h8, 1, 64'h0};
    tbl[4] = '{1, 1, 64'hc, 1, 64'h4};
    tbl[5] = '{1, 1, 64'h10, 1, 64'h8};
    // boot timing and streaming throughput
    do_reset(1);
    push_seq(0, 12);
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].rdy, 0, 0, 0);
      chk("vec_req_valid", imem_req_valid, tbl[i].exp_rv);
      if (tbl[i].exp_rv) chk("vec_req_addr", imem_req_addr, tbl[i].exp_addr);
      chk("vec_out_valid", out_valid, tbl[i].exp_ov);
      chk("vec_out_pc", out_pc, tbl[i].exp_pc);
      finish_cyc();
    end
    run_out(40);
    // credit limit with decode stalled
    do_reset(1);
    repeat (12) step(0, 0, 0, 0);
    chk("credit_fires", fires, 4);
    chk("credit_stall_valid", imem_req_valid, 0);
    chk("full_head_pc", out_pc, 0);
    push_seq(0, 8);
    run_out(40);
    // redirect with three requests in flight under 3-cycle latency
    do_reset(3);
    push_seq(64'h100, 4);
    repeat (4) step(1, 0, 0, 0);
    step(1, 0, 1, 64'h100);
    drive(1, 0, 0, 0);
    chk("redir_out_valid", out_valid, 0);
    chk("redir_req_valid", imem_req_valid, 1);
    chk("redir_req_addr", imem_req_addr, 64'h100);
    finish_cyc();
    run_out(40);
    // redirect coincident with a response and a dequeue
    do_reset(1);
    push_seq(0, 3);
    push_seq(64'h200, 4);
    repeat (5) step(1, 0, 0, 0);
    step(1, 0, 1, 64'h200);
    drive(1, 0, 0, 0);
    chk("coinc_out_valid", out_valid, 0);
    finish_cyc();
    run_out(40);
    // halt for five cycles
    do_reset(1);
    push_seq(0, 10);
    repeat (5) step(1, 0, 0, 0);
    fires0 = fires;
    repeat (5) step(1, 1, 0, 0);
    chk("halt_fires", fires - fires0, 0);
    chk("halt_drained", out_valid, 0);
    run_out(60);
    // boot-cycle redirect ignored, then address wrap
    do_reset(1);
    step(1, 0, 1, 64'h500);
    exp_addr = 0;
    step(1, 0, 0, 0);
    push_seq(64'hFFFF_FFFF_FFFF_FFFC, 3);
    step(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    run_out(40);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
